// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad front-end and the downstream key decoding.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam int KEY_W    = 5;
    localparam int NUM_KEYS = 16;
    localparam logic [KEY_W-1:0] NO_KEY = 5'h10;

endpackage

// File: rtl/key_encoder.sv
// Combinational encoder: lowest set bit index plus one-hot and empty flags.
module key_encoder
    import keypad_pkg::*;
(
    input  logic [NUM_KEYS-1:0] vec,
    output logic [3:0]          index,
    output logic                one_hot,
    output logic                none
);

    logic [4:0] ones_s;

    // Scan from the top so the lowest set bit wins the index
    always_comb begin
        index  = 4'd0;
        ones_s = 5'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            ones_s = ones_s + {4'd0, vec[i]};
            if (vec[i]) begin
                index = 4'(i);
            end else begin
                index = index;
            end
        end
        one_hot = (ones_s == 5'd1);
        none    = (ones_s == 5'd0);
    end

endmodule

// File: rtl/keypad_debouncer.sv
// Synchronises and debounces the raw keypad, emitting one strobe per accepted press
// with optional auto-repeat while a single key is held.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 41600,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic                clk_i,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] buttons,
    output logic [KEY_W-1:0]    key_value,
    output logic                key_valid,
    output logic                key_multi,
    output logic                busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit REP_EN = (REPEAT_CYCLES > 0);

    logic [NUM_KEYS-1:0] meta_r, sync_r, sync_prev_r;
    logic [CNT_W-1:0]    db_cnt_r;
    logic [REP_W-1:0]    rep_cnt_r, rep_next_s;
    state_t              state_r, state_next_s;
    logic [KEY_W-1:0]    key_value_r, key_value_next_s;
    logic                key_valid_r, key_valid_next_s;
    logic                key_multi_r, key_multi_next_s;
    logic                busy_r;
    logic                changed_s, stable_s;
    logic [3:0]          enc_index_s;
    logic                enc_one_hot_s, enc_none_s;

    key_encoder u_enc (
        .vec     (sync_r),
        .index   (enc_index_s),
        .one_hot (enc_one_hot_s),
        .none    (enc_none_s)
    );

    assign changed_s = (sync_r != sync_prev_r);
    assign stable_s  = !changed_s && (db_cnt_r == DB_LAST);

    // Two-flop synchroniser plus the previous-cycle copy used for change detection
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            meta_r      <= '0;
            sync_r      <= '0;
            sync_prev_r <= '0;
        end else begin
            meta_r      <= buttons;
            sync_r      <= meta_r;
            sync_prev_r <= sync_r;
        end
    end

    // Stability counter: restarts on any change, saturates at the last debounce cycle
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_r <= '0;
        end else if (changed_s) begin
            db_cnt_r <= '0;
        end else if (db_cnt_r != DB_LAST) begin
            db_cnt_r <= db_cnt_r + 1'b1;
        end else begin
            db_cnt_r <= db_cnt_r;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_next_s     = state_r;
        key_value_next_s = key_value_r;
        key_valid_next_s = 1'b0;
        key_multi_next_s = 1'b0;
        rep_next_s       = '0;
        case (state_r)
            IDLE: begin
                if (!enc_none_s) begin
                    state_next_s = PRESS_DB;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRESS_DB: begin
                if (enc_none_s) begin
                    state_next_s = IDLE;
                end else if (stable_s) begin
                    state_next_s = HELD;
                    if (enc_one_hot_s) begin
                        key_value_next_s = {1'b0, enc_index_s};
                        key_valid_next_s = 1'b1;
                    end else begin
                        key_multi_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = PRESS_DB;
                end
            end
            HELD: begin
                if (enc_none_s) begin
                    state_next_s = RELEASE_DB;
                end else if (REP_EN && (key_value_r != NO_KEY)) begin
                    // A multi-key press leaves NO_KEY, which also suppresses repeat
                    if (rep_cnt_r == REP_LAST) begin
                        key_valid_next_s = 1'b1;
                        rep_next_s       = '0;
                    end else begin
                        rep_next_s = rep_cnt_r + 1'b1;
                    end
                end else begin
                    rep_next_s = '0;
                end
            end
            RELEASE_DB: begin
                if (!enc_none_s) begin
                    state_next_s = HELD;
                end else if (stable_s) begin
                    state_next_s     = IDLE;
                    key_value_next_s = NO_KEY;
                end else begin
                    state_next_s = RELEASE_DB;
                end
            end
            default: begin
                state_next_s     = IDLE;
                key_value_next_s = NO_KEY;
            end
        endcase
    end

    // State, repeat counter and output registers
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            rep_cnt_r   <= '0;
            key_value_r <= NO_KEY;
            key_valid_r <= 1'b0;
            key_multi_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rep_cnt_r   <= rep_next_s;
            key_value_r <= key_value_next_s;
            key_valid_r <= key_valid_next_s;
            key_multi_r <= key_multi_next_s;
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign key_value = key_value_r;
    assign key_valid = key_valid_r;
    assign key_multi = key_multi_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with DEBOUNCE_CYCLES=4; a second instance
// with REPEAT_CYCLES=10 shares the stimulus for the auto-repeat checks.
module tb_keypad_debouncer;

    logic        clk_i = 1'b0;
    logic        reset_n;
    logic [15:0] buttons;
    logic [4:0]  key_value, rkey_value;
    logic        key_valid, key_multi, busy;
    logic        rkey_valid, rkey_multi, rbusy;

    int checks = 0;
    int errors = 0;
    int nv, fv, nm, fm, nvr, fvr, lvr, fidle, fnk;

    always #5 clk_i = ~clk_i;

    keypad_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)) dut (
        .clk_i(clk_i), .reset_n(reset_n), .buttons(buttons),
        .key_value(key_value), .key_valid(key_valid), .key_multi(key_multi), .busy(busy)
    );

    keypad_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(10)) dut_rep (
        .clk_i(clk_i), .reset_n(reset_n), .buttons(buttons),
        .key_value(rkey_value), .key_valid(rkey_valid), .key_multi(rkey_multi), .busy(rbusy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample n falling edges, recording strobe counts and first/last positions (1-based)
    task automatic window(input int n);
        nv = 0; fv = 0; nm = 0; fm = 0; nvr = 0; fvr = 0; lvr = 0; fidle = 0; fnk = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk_i);
            if (key_valid) begin nv++; if (fv == 0) fv = i; end
            if (key_multi) begin nm++; if (fm == 0) fm = i; end
            if (rkey_valid) begin nvr++; if (fvr == 0) fvr = i; lvr = i; end
            if (!busy && fidle == 0) fidle = i;
            if (key_value == 5'h10 && fnk == 0) fnk = i;
        end
    endtask

    initial begin
        int bv, bm;
        reset_n = 1'b0;
        buttons = 16'h0000;
        repeat (3) @(negedge clk_i);
        check("rst_value", key_value, 5'h10);
        check("rst_valid", key_valid, 1'b0);
        check("rst_multi", key_multi, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        window(6);
        check("idle_busy", busy, 1'b0);

        // Clean press of key 3 and its release
        buttons = 16'h0008;
        window(12);
        check("clean_nvalid", nv, 1);
        check("clean_latency", fv, 7);
        check("clean_nmulti", nm, 0);
        check("clean_value", key_value, 5'd3);
        check("clean_busy", busy, 1'b1);
        buttons = 16'h0000;
        window(12);
        check("clean_rel_nokey", fnk, 7);
        check("clean_rel_idle", fidle, 7);

        // Bounce on bit 5, then hold
        bv = 0; bm = 0;
        for (int k = 0; k < 10; k++) begin
            buttons = (k % 2 == 0) ? 16'h0020 : 16'h0000;
            window(2);
            bv += nv; bm += nm;
        end
        check("bounce_quiet_valid", bv, 0);
        check("bounce_quiet_multi", bm, 0);
        buttons = 16'h0020;
        window(12);
        check("bounce_nvalid", nv, 1);
        check("bounce_latency", fv, 7);
        check("bounce_value", key_value, 5'd5);
        buttons = 16'h0000;
        window(12);
        check("bounce_rel_idle", fidle, 7);

        // Multi-key press: strobe key_multi, never key_valid, no repeat
        buttons = 16'h0101;
        window(30);
        check("multi_nvalid", nv, 0);
        check("multi_nmulti", nm, 1);
        check("multi_latency", fm, 7);
        check("multi_value", key_value, 5'h10);
        check("multi_no_repeat", nvr, 0);
        buttons = 16'h0000;
        window(12);
        check("multi_rel_idle", fidle, 7);

        // Key swap while held is ignored
        buttons = 16'h0004;
        window(12);
        check("swap_first", nv, 1);
        check("swap_value", key_value, 5'd2);
        buttons = 16'h0080;
        window(12);
        check("swap_nvalid", nv, 0);
        check("swap_nmulti", nm, 0);
        check("swap_value_held", key_value, 5'd2);
        buttons = 16'h0000;
        window(12);
        check("swap_rel_nokey", fnk, 7);

        // Auto-repeat on key 15 with REPEAT_CYCLES=10
        buttons = 16'h8000;
        window(47);
        check("rep_off_nvalid", nv, 1);
        check("rep_npulses", nvr, 5);
        check("rep_first", fvr, 7);
        check("rep_last", lvr, 47);
        check("rep_value", rkey_value, 5'd15);
        buttons = 16'h0000;
        window(15);
        check("rep_rel_quiet", nvr, 0);
        check("rep_rel_value", rkey_value, 5'h10);

        // Asynchronous reset while HELD, then a fresh press with the key still down
        buttons = 16'h0010;
        window(12);
        check("mid_first", nv, 1);
        check("mid_value", key_value, 5'd4);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_value", key_value, 5'h10);
        check("mid_rst_valid", key_valid, 1'b0);
        check("mid_rst_multi", key_multi, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk_i);
        reset_n = 1'b1;
        window(12);
        check("mid_again_nvalid", nv, 1);
        check("mid_again_latency", fv, 7);
        check("mid_again_value", key_value, 5'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
